bip2_program_loader: RTL and testbench
======================================

BIP2_PROGRAM_LOADER -- requirements
Module: bip2_program_loader

Interface
REQ-001 SHALL have parameter OPERAND_ADDRESS_WIDTH, default 11: instruction memory address width.
REQ-002 SHALL have parameter INSTRUCTION_DATA_WIDTH, default 16: instruction word width, built from two bytes.
REQ-003 SHALL have port clock_in  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_in  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port byte_in  input  8: incoming load-stream byte.
REQ-006 SHALL have port byte_valid_in  input  1: byte_in valid this cycle.
REQ-007 SHALL have port byte_ready_out  output  1: loader accepts a byte this cycle.
REQ-008 SHALL have port start_in  input  1: request reload; honoured only in DONE or ERROR.
REQ-009 SHALL have port instr_mem_wr_out  output  1: instruction memory write strobe.
REQ-010 SHALL have port instr_mem_address_out  output  OPERAND_ADDRESS_WIDTH: write address.
REQ-011 SHALL have port instr_mem_data_out  output  INSTRUCTION_DATA_WIDTH: write data.
REQ-012 SHALL have port cpu_reset_out  output  1: active-low reset to BIP2; 0 holds the CPU in reset.
REQ-013 SHALL have port load_done_out  output  1: program loaded, CPU released.
REQ-014 SHALL have port error_out  output  1: word count exceeds memory capacity.

Function
REQ-015 Stream format SHALL be: count high byte, count low byte (16-bit N), then N words, each high byte first, low byte second.
REQ-016 SHALL implement states COUNT_HI, COUNT_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR.
REQ-017 A byte SHALL be accepted only on a rising edge with byte_valid_in=1 and byte_ready_out=1.
REQ-018 byte_ready_out SHALL be 1 in COUNT_HI, COUNT_LO, DATA_HI and DATA_LO, and 0 in WRITE, DONE and ERROR.
REQ-019 Transitions: COUNT_HI->COUNT_LO on accept; COUNT_LO->DATA_HI if 1<=N<=2^OPERAND_ADDRESS_WIDTH, ->DONE if N=0, ->ERROR if N>2^OPERAND_ADDRESS_WIDTH.
REQ-020 DATA_HI SHALL go to DATA_LO on accept; DATA_LO SHALL go to WRITE on accept.
REQ-021 WRITE SHALL last exactly one cycle, with instr_mem_wr_out=1, data={high,low} and the current address.
REQ-022 The address SHALL increment by 1 on leaving WRITE; WRITE SHALL go to DONE after word N, else to DATA_HI.
REQ-023 instr_mem_wr_out SHALL be 0 in every state except WRITE; address and data SHALL hold their last values otherwise.
REQ-024 The full-capacity load N=2048 SHALL write addresses 0..2047; the address register wraps to 0 after the final write, which is harmless.
REQ-025 In DONE: cpu_reset_out=1, load_done_out=1, error_out=0.
REQ-026 In ERROR: error_out=1, cpu_reset_out=0, load_done_out=0, and no memory writes.
REQ-027 start_in=1 in DONE or ERROR SHALL, next edge, go to COUNT_HI with address=0, cpu_reset_out=0, load_done_out=0, error_out=0.
REQ-028 start_in SHALL be ignored in all other states.
REQ-029 cpu_reset_out SHALL be 0 in every state except DONE; the CPU never runs a partially loaded program.
REQ-030 Once DONE is entered, byte_valid_in activity SHALL NOT affect any output.

Reset
REQ-031 reset_in=0 SHALL immediately force state COUNT_HI, address=0, data=0, instr_mem_wr_out=0, cpu_reset_out=0, load_done_out=0, error_out=0, byte_ready_out=1 once released.
REQ-032 Reset asserted mid-load, including during WRITE, SHALL abort the load and drop the write strobe asynchronously; the load restarts from the count bytes.

Verification
REQ-033 Stream 00 02 28 2A 08 01 with valid held high -> writes 0x282A@0 and 0x0801@1, each with a one-cycle strobe, then DONE with cpu_reset_out=1.
REQ-034 Stream 00 00 -> DONE two accepts later, zero writes, load_done_out=1.
REQ-035 Stream 08 01 (N=2049) -> ERROR, error_out=1, cpu_reset_out=0; a later start_in pulse -> COUNT_HI with error cleared.
REQ-036 N=2048 with random valid gaps -> 2048 writes at addresses 0..2047 in order, no accepts during WRITE, then DONE.
REQ-037 reset_in driven low during the WRITE of word 3 of a 5-word load -> strobe falls at once; after release, a full reload is required before DONE.
REQ-038 start_in pulsed in DATA_HI -> ignored, and the load completes normally.

Source files
------------

// File: rtl/bip2_program_loader.sv
// Byte-stream program loader for the BIP2 core: receives a 16-bit word count and then
// that many big-endian words, writes them to instruction memory, and releases the CPU.
module bip2_program_loader #(
  parameter int OPERAND_ADDRESS_WIDTH  = 11,
  parameter int INSTRUCTION_DATA_WIDTH = 16
) (
  input  logic                              clock_in,
  input  logic                              reset_in,
  input  logic [7:0]                        byte_in,
  input  logic                              byte_valid_in,
  output logic                              byte_ready_out,
  input  logic                              start_in,
  output logic                              instr_mem_wr_out,
  output logic [OPERAND_ADDRESS_WIDTH-1:0]  instr_mem_address_out,
  output logic [INSTRUCTION_DATA_WIDTH-1:0] instr_mem_data_out,
  output logic                              cpu_reset_out,
  output logic                              load_done_out,
  output logic                              error_out
);

  localparam int AW = OPERAND_ADDRESS_WIDTH;
  localparam int DW = INSTRUCTION_DATA_WIDTH;
  // One word per address, so the largest legal count is the full address space.
  localparam logic [16:0] CAPACITY = 17'(1) << AW;

  typedef enum logic [2:0] {
    COUNT_HI,
    COUNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     rem_q, rem_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            wr_q, wr_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;

  logic            accept;
  logic [15:0]     count_w;

  assign accept  = byte_valid_in & ready_q;
  assign count_w = {hi_q, byte_in};

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d = state_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      COUNT_HI: if (accept) begin
        hi_d    = byte_in;
        state_d = COUNT_LO;
      end
      COUNT_LO: if (accept) begin
        rem_d = count_w;
        if (count_w == 16'd0)                 state_d = DONE;
        else if ({1'b0, count_w} > CAPACITY)  state_d = ERROR;
        else                                  state_d = DATA_HI;
      end
      DATA_HI: if (accept) begin
        hi_d    = byte_in;
        state_d = DATA_LO;
      end
      DATA_LO: if (accept) begin
        data_d  = DW'({hi_q, byte_in});
        state_d = WRITE;
      end
      WRITE: begin
        // After word 2^AW the address wraps to zero; nothing is written there.
        addr_d  = addr_q + AW'(1);
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? DONE : DATA_HI;
      end
      DONE, ERROR: if (start_in) begin
        addr_d  = '0;
        state_d = COUNT_HI;
      end
      default: state_d = COUNT_HI;
    endcase

    // Outputs are registered: decode them from the state being entered.
    wr_d      = (state_d == WRITE);
    cpu_rst_d = (state_d == DONE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERROR);
    ready_d   = (state_d == COUNT_HI) || (state_d == COUNT_LO) ||
                (state_d == DATA_HI)  || (state_d == DATA_LO);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= COUNT_HI;
      hi_q      <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign byte_ready_out        = ready_q;
  assign instr_mem_wr_out      = wr_q;
  assign instr_mem_address_out = addr_q;
  assign instr_mem_data_out    = data_q;
  assign cpu_reset_out         = cpu_rst_q;
  assign load_done_out         = done_q;
  assign error_out             = err_q;

endmodule

// File: tb/tb_bip2_program_loader.sv
// Self-checking bench for bip2_program_loader: table of short load streams plus
// directed sequences for full-capacity load, mid-write reset and ignored start pulses.
module tb_bip2_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_ready_out;
  logic        start_in;
  logic        instr_mem_wr_out;
  logic [10:0] instr_mem_address_out;
  logic [15:0] instr_mem_data_out;
  logic        cpu_reset_out;
  logic        load_done_out;
  logic        error_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bip2_program_loader dut (
    .clock_in              (clk),
    .reset_in              (rst_n),
    .byte_in               (byte_in),
    .byte_valid_in         (byte_valid_in),
    .byte_ready_out        (byte_ready_out),
    .start_in              (start_in),
    .instr_mem_wr_out      (instr_mem_wr_out),
    .instr_mem_address_out (instr_mem_address_out),
    .instr_mem_data_out    (instr_mem_data_out),
    .cpu_reset_out         (cpu_reset_out),
    .load_done_out         (load_done_out),
    .error_out             (error_out)
  );

  // Write monitor: WRITE lasts one cycle, so each high strobe seen at a negedge is one write.
  logic [10:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          long_strobes = 0;
  int          accept_in_write = 0;
  logic        prev_wr = 1'b0;

  always @(negedge clk) begin
    if (instr_mem_wr_out) begin
      wr_addr.push_back(instr_mem_address_out);
      wr_data.push_back(instr_mem_data_out);
      if (prev_wr) long_strobes++;
      if (byte_ready_out) accept_in_write++;
    end
    prev_wr = instr_mem_wr_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   budget;
    logic acc;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in       = b;
    byte_valid_in = 1'b1;
    budget        = 200;
    acc           = 1'b0;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = byte_ready_out;
      @(posedge clk); #1;
      budget--;
    end
    byte_valid_in = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  typedef struct packed {
    logic [63:0] bytes;
    logic [3:0]  len;
    logic [1:0]  nw;
    logic [47:0] words;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst_n = 1'b0; byte_in = 8'h00; byte_valid_in = 1'b0; start_in = 1'b0;

    vecs[0] = '{64'h0002_282A_0801_0000, 4'd6, 2'd2, 48'h282A_0801_0000, 1'b1, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_0000, 4'd2, 2'd0, 48'h0,              1'b1, 1'b0};
    vecs[2] = '{64'h0801_0000_0000_0000, 4'd2, 2'd0, 48'h0,              1'b0, 1'b1};
    vecs[3] = '{64'h0001_ABCD_0000_0000, 4'd4, 2'd1, 48'hABCD_0000_0000, 1'b1, 1'b0};
    vecs[4] = '{64'h0003_1122_3344_5566, 4'd8, 2'd3, 48'h1122_3344_5566, 1'b1, 1'b0};
    vecs[5] = '{64'hFFFF_0000_0000_0000, 4'd2, 2'd0, 48'h0,              1'b0, 1'b1};

    // Reset state
    #3;
    check("rst_wr",       32'(instr_mem_wr_out), 32'd0);
    check("rst_cpu",      32'(cpu_reset_out), 32'd0);
    check("rst_done",     32'(load_done_out), 32'd0);
    check("rst_err",      32'(error_out), 32'd0);
    check("rst_addr",     32'(instr_mem_address_out), 32'd0);
    check("rst_data",     32'(instr_mem_data_out), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready",    32'(byte_ready_out), 32'd1);

    // Table-driven streams
    for (int v = 0; v < 6; v++) begin
      clear_log();
      for (int k = 0; k < int'(vecs[v].len); k++)
        send_byte(vecs[v].bytes[63-8*k -: 8], 0);
      idle(3);
      check($sformatf("v%0d_nwrites", v), 32'(wr_addr.size()), 32'(vecs[v].nw));
      for (int k = 0; k < int'(vecs[v].nw) && k < wr_addr.size(); k++) begin
        check($sformatf("v%0d_addr%0d", v, k), 32'(wr_addr[k]), 32'(k));
        check($sformatf("v%0d_data%0d", v, k), 32'(wr_data[k]), 32'(vecs[v].words[47-16*k -: 16]));
      end
      check($sformatf("v%0d_done", v),  32'(load_done_out), 32'(vecs[v].done));
      check($sformatf("v%0d_cpu", v),   32'(cpu_reset_out), 32'(vecs[v].done));
      check($sformatf("v%0d_err", v),   32'(error_out),     32'(vecs[v].err));
      check($sformatf("v%0d_ready", v), 32'(byte_ready_out), 32'd0);
      if (vecs[v].nw != 2'd0) begin
        check($sformatf("v%0d_addr_hold", v), 32'(instr_mem_address_out), 32'(vecs[v].nw));
        check($sformatf("v%0d_data_hold", v), 32'(instr_mem_data_out),
              32'(vecs[v].words[47-16*(int'(vecs[v].nw)-1) -: 16]));
      end
      pulse_start();
      check($sformatf("v%0d_restart_ready", v), 32'(byte_ready_out), 32'd1);
      check($sformatf("v%0d_restart_err", v),   32'(error_out), 32'd0);
      check($sformatf("v%0d_restart_done", v),  32'(load_done_out), 32'd0);
      check($sformatf("v%0d_restart_cpu", v),   32'(cpu_reset_out), 32'd0);
      check($sformatf("v%0d_restart_addr", v),  32'(instr_mem_address_out), 32'd0);
    end

    // Zero-count load reaches DONE right on the second accept
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("zero_done_immediate", 32'(load_done_out), 32'd1);
    pulse_start();

    // start_in during DATA_HI is ignored
    clear_log();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    pulse_start();
    check("start_ignored_ready", 32'(byte_ready_out), 32'd1);
    check("start_ignored_addr",  32'(instr_mem_address_out), 32'd0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h56, 0); send_byte(8'h78, 0);
    idle(3);
    check("start_ignored_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_data.size() == 2) begin
      check("start_ignored_d0", 32'(wr_data[0]), 32'h1234);
      check("start_ignored_d1", 32'(wr_data[1]), 32'h5678);
    end
    check("start_ignored_done", 32'(load_done_out), 32'd1);

    // Byte traffic in DONE changes nothing
    for (int i = 0; i < 6; i++) begin
      byte_in = 8'(8'hC0 + i); byte_valid_in = 1'b1;
      @(posedge clk); #1;
      check($sformatf("done_hold_%0d", i),
            {28'd0, load_done_out, cpu_reset_out, error_out, instr_mem_wr_out}, 32'hC);
    end
    byte_valid_in = 1'b0;
    check("done_hold_nwrites", 32'(wr_addr.size()), 32'd2);
    pulse_start();

    // Full-capacity load with random valid gaps
    begin
      int bad = 0;
      logic [15:0] w;
      clear_log();
      send_byte(8'h08, $urandom_range(0, 2));
      send_byte(8'h00, $urandom_range(0, 2));
      for (int i = 0; i < 2048; i++) begin
        w = 16'(i * 7) ^ 16'hA5C3;
        send_byte(w[15:8], $urandom_range(0, 2));
        send_byte(w[7:0],  $urandom_range(0, 2));
      end
      idle(3);
      check("full_nwrites", 32'(wr_addr.size()), 32'd2048);
      for (int i = 0; i < wr_addr.size(); i++) begin
        w = 16'(i * 7) ^ 16'hA5C3;
        if (wr_addr[i] !== 11'(i) || wr_data[i] !== w) bad++;
      end
      check("full_contents_bad", 32'(bad), 32'd0);
      check("full_done", 32'(load_done_out), 32'd1);
      check("full_cpu",  32'(cpu_reset_out), 32'd1);
      check("full_addr_wrap", 32'(instr_mem_address_out), 32'd0);
      pulse_start();
    end

    // Reset during the WRITE of word 3 of a 5-word load
    clear_log();
    send_byte(8'h00, 0); send_byte(8'h05, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h10 + i), 0);
      send_byte(8'(8'h20 + i), 0);
    end
    check("midrst_wr_before", 32'(instr_mem_wr_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_dropped", 32'(instr_mem_wr_out), 32'd0);
    check("midrst_cpu",        32'(cpu_reset_out), 32'd0);
    check("midrst_addr",       32'(instr_mem_address_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(byte_ready_out), 32'd1);
    idle(5);
    check("midrst_not_done", 32'(load_done_out), 32'd0);
    clear_log();
    send_byte(8'h00, 0); send_byte(8'h05, 0);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h30 + i), 1);
      send_byte(8'(8'h40 + i), 0);
    end
    idle(3);
    check("reload_nwrites", 32'(wr_addr.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_addr.size(); i++) begin
      check($sformatf("reload_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("reload_data%0d", i), 32'(wr_data[i]), 32'({8'(8'h30 + i), 8'(8'h40 + i)}));
    end
    check("reload_done", 32'(load_done_out), 32'd1);

    check("strobe_one_cycle", 32'(long_strobes), 32'd0);
    check("no_accept_in_write", 32'(accept_in_write), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
